// File: rtl/regfile_sb.sv
// regfile_sb: parameterised register file with a pending-write scoreboard.
// It has DEPTH x DATA_W storage, NUM_READ combinational read ports and one clocked write port.
// Register 0 can be hardwired to zero (ZERO_REG=1).
// The scoreboard tracks registers that have an issued producer whose writeback has not
// arrived yet. Readers use it to detect RAW hazards (ReadReady) and the issuer uses it to
// detect WAW hazards (IssueBusy).
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a same-cycle writeback is
// forwarded to any read port addressing the register being written.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_READ = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            WriteReg,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic                         Issue,
  input  logic [ADDR_W-1:0]            IssueReg,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadReg,
  output logic [NUM_READ*DATA_W-1:0]   ReadData,
  output logic [NUM_READ-1:0]          ReadReady,
  output logic                         IssueBusy
);

  // DEPTH widened by one bit, so that the range compare also works when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DepthLimit = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic writeOk;
  logic issueOk;

  // True when the index addresses a physical register.
  function automatic logic inRange(input logic [ADDR_W-1:0] idx);
    return ({1'b0, idx} < DepthLimit);
  endfunction

  // True when the index addresses a real register that can be written or marked pending.
  // A hardwired zero register is excluded.
  function automatic logic isWritable(input logic [ADDR_W-1:0] idx);
    return inRange(idx) && !(ZERO_REG && (idx == '0));
  endfunction

  assign writeOk = RegWrite && isWritable(WriteReg);
  assign issueOk = Issue && isWritable(IssueReg);

  // Register storage: cleared on reset; writebacks to legal indices update one entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (writeOk) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Scoreboard: a writeback clears a mark and an issue sets one.
  // The issue assignment comes second, so on a same-index collision the new producer wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      if (writeOk) begin
        pending[WriteReg] <= 1'b0;
      end
      if (issueOk) begin
        pending[IssueReg] <= 1'b1;
      end
    end
  end

  // WAW indicator. Out-of-range indices and the zero register are never pending.
  always_comb begin
    IssueBusy = isWritable(IssueReg) && pending[IssueReg];
  end

  genvar p;
  generate
    for (p = 0; p < NUM_READ; p++) begin : gRead
      logic [ADDR_W-1:0] readIdx;
      assign readIdx = ReadReg[p*ADDR_W +: ADDR_W];

      // Combinational read port. Out-of-range and zero-register reads return 0 and are always ready.
      always_comb begin
        ReadData[p*DATA_W +: DATA_W] = '0;
        ReadReady[p]                 = 1'b1;
        if (isWritable(readIdx)) begin
          ReadData[p*DATA_W +: DATA_W] = regs[readIdx];
          ReadReady[p]                 = !pending[readIdx];
        end
`ifdef REGFILE_BYPASS_EN
        if (reset_n && writeOk && (WriteReg == readIdx)) begin
          ReadData[p*DATA_W +: DATA_W] = WriteData;
          ReadReady[p]                 = 1'b1;
        end
`endif
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed, self-checking bench for regfile_sb.
// The main instance uses the default parameters: 32 registers, two read ports and a hardwired zero register.
// A second instance uses DEPTH=24 and ZERO_REG=0, to exercise out-of-range indices and a writable register 0.
// Expectations for same-cycle forwarding follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

  logic        clock;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Issue;
  logic [4:0]  IssueReg;
  logic [9:0]  ReadReg;
  logic [63:0] ReadData;
  logic [1:0]  ReadReady;
  logic        IssueBusy;

  logic        rw2;
  logic [4:0]  wr2;
  logic [31:0] wd2;
  logic        is2;
  logic [4:0]  ir2;
  logic [4:0]  rr2;
  logic [31:0] rd2;
  logic [0:0]  rdy2;
  logic        busy2;

  int checks;
  int errors;

  regfile_sb dut (
    .clock(clock), .reset_n(reset_n),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .Issue(Issue), .IssueReg(IssueReg),
    .ReadReg(ReadReg), .ReadData(ReadData), .ReadReady(ReadReady),
    .IssueBusy(IssueBusy)
  );

  regfile_sb #(.DATA_W(32), .DEPTH(24), .NUM_READ(1), .ZERO_REG(1'b0)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .RegWrite(rw2), .WriteReg(wr2), .WriteData(wd2),
    .Issue(is2), .IssueReg(ir2),
    .ReadReg(rr2), .ReadData(rd2), .ReadReady(rdy2),
    .IssueBusy(busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    RegWrite = 0; WriteReg = 0; WriteData = 0;
    Issue = 0; IssueReg = 0;
    ReadReg = {5'd3, 5'd5};
    rw2 = 0; wr2 = 0; wd2 = 0; is2 = 0; ir2 = 0; rr2 = 0;
    #2;
    checks++; if (ReadData !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", ReadData, 64'h0); end
    checks++; if (ReadReady !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected %b", ReadReady, 2'b11); end
    checks++; if (IssueBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", IssueBusy, 1'b0); end
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_write_read();
    RegWrite = 1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
    step();
    RegWrite = 0;
    #1;
    checks++; if (ReadData[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r5: got %h expected %h", ReadData[31:0], 32'hDEADBEEF); end
    checks++; if (ReadData[63:32] !== 32'h0) begin errors++; $display("FAIL untouched_r3: got %h expected %h", ReadData[63:32], 32'h0); end
    checks++; if (ReadReady !== 2'b11) begin errors++; $display("FAIL write_ready: got %b expected %b", ReadReady, 2'b11); end
  endtask

  task automatic test_zero_reg();
    RegWrite = 1; WriteReg = 5'd0; WriteData = 32'h12345678;
    ReadReg = {5'd5, 5'd0};
    step();
    RegWrite = 0;
    #1;
    checks++; if (ReadData[31:0] !== 32'h0) begin errors++; $display("FAIL zero_data: got %h expected %h", ReadData[31:0], 32'h0); end
    checks++; if (ReadReady[0] !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected %b", ReadReady[0], 1'b1); end
    Issue = 1; IssueReg = 5'd0;
    step();
    Issue = 0;
    #1;
    checks++; if (IssueBusy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected %b", IssueBusy, 1'b0); end
    checks++; if (ReadReady[0] !== 1'b1) begin errors++; $display("FAIL zero_ready_after_issue: got %b expected %b", ReadReady[0], 1'b1); end
  endtask

  task automatic test_issue_pending();
    Issue = 1; IssueReg = 5'd7;
    step();
    Issue = 0;
    ReadReg = {5'd7, 5'd7};
    #1;
    checks++; if (ReadReady !== 2'b00) begin errors++; $display("FAIL r7_pending_ready: got %b expected %b", ReadReady, 2'b00); end
    checks++; if (IssueBusy !== 1'b1) begin errors++; $display("FAIL r7_busy: got %b expected %b", IssueBusy, 1'b1); end
    RegWrite = 1; WriteReg = 5'd7; WriteData = 32'hA5;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (ReadReady !== 2'b11) begin errors++; $display("FAIL r7_wb_cycle_ready: got %b expected %b", ReadReady, 2'b11); end
`else
    checks++; if (ReadReady !== 2'b00) begin errors++; $display("FAIL r7_wb_cycle_ready: got %b expected %b", ReadReady, 2'b00); end
`endif
    step();
    RegWrite = 0;
    #1;
    checks++; if (ReadReady !== 2'b11) begin errors++; $display("FAIL r7_ready_after_wb: got %b expected %b", ReadReady, 2'b11); end
    checks++; if (ReadData !== {32'hA5, 32'hA5}) begin errors++; $display("FAIL r7_data_after_wb: got %h expected %h", ReadData, {32'hA5, 32'hA5}); end
    checks++; if (IssueBusy !== 1'b0) begin errors++; $display("FAIL r7_busy_cleared: got %b expected %b", IssueBusy, 1'b0); end
  endtask

  task automatic test_same_cycle();
    Issue = 1; IssueReg = 5'd9;
    RegWrite = 1; WriteReg = 5'd9; WriteData = 32'h55;
    ReadReg = {5'd7, 5'd9};
    step();
    Issue = 0; RegWrite = 0;
    #1;
    checks++; if (ReadData[31:0] !== 32'h55) begin errors++; $display("FAIL r9_data: got %h expected %h", ReadData[31:0], 32'h55); end
    checks++; if (ReadReady !== 2'b10) begin errors++; $display("FAIL r9_ready: got %b expected %b", ReadReady, 2'b10); end
    checks++; if (IssueBusy !== 1'b1) begin errors++; $display("FAIL r9_busy: got %b expected %b", IssueBusy, 1'b1); end
  endtask

  task automatic test_bypass();
    RegWrite = 1; WriteReg = 5'd4; WriteData = 32'h11;
    step();
    RegWrite = 0;
    Issue = 1; IssueReg = 5'd4;
    step();
    Issue = 0;
    ReadReg = {5'd4, 5'd4};
    RegWrite = 1; WriteReg = 5'd4; WriteData = 32'h77;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (ReadData !== {32'h77, 32'h77}) begin errors++; $display("FAIL r4_same_cycle_data: got %h expected %h", ReadData, {32'h77, 32'h77}); end
    checks++; if (ReadReady !== 2'b11) begin errors++; $display("FAIL r4_same_cycle_ready: got %b expected %b", ReadReady, 2'b11); end
`else
    checks++; if (ReadData !== {32'h11, 32'h11}) begin errors++; $display("FAIL r4_same_cycle_data: got %h expected %h", ReadData, {32'h11, 32'h11}); end
    checks++; if (ReadReady !== 2'b00) begin errors++; $display("FAIL r4_same_cycle_ready: got %b expected %b", ReadReady, 2'b00); end
`endif
    step();
    RegWrite = 0;
    #1;
    checks++; if (ReadData !== {32'h77, 32'h77}) begin errors++; $display("FAIL r4_after_edge_data: got %h expected %h", ReadData, {32'h77, 32'h77}); end
    checks++; if (ReadReady !== 2'b11) begin errors++; $display("FAIL r4_after_edge_ready: got %b expected %b", ReadReady, 2'b11); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h1010_0001; vals[1] = 32'h2020_0002;
    vals[2] = 32'h3030_0003; vals[3] = 32'h4040_0004;
    for (int k = 0; k < 4; k++) begin
      RegWrite = 1; WriteReg = 5'(10 + k); WriteData = vals[k];
      step();
    end
    RegWrite = 0;
    for (int k = 0; k < 4; k += 2) begin
      ReadReg = {5'(11 + k), 5'(10 + k)};
      #1;
      checks++; if (ReadData !== {vals[k+1], vals[k]}) begin errors++; $display("FAIL b2b_pair%0d: got %h expected %h", k, ReadData, {vals[k+1], vals[k]}); end
    end
  endtask

  task automatic test_out_of_range();
    rw2 = 1; wr2 = 5'd0; wd2 = 32'hCAFE;
    step();
    rw2 = 1; wr2 = 5'd25; wd2 = 32'hBAD;
    rr2 = 5'd0;
    #1;
    checks++; if (rd2 !== 32'hCAFE) begin errors++; $display("FAIL d2_r0_writable: got %h expected %h", rd2, 32'hCAFE); end
    step();
    rw2 = 0;
    rr2 = 5'd25;
    #1;
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL d2_oob_data: got %h expected %h", rd2, 32'h0); end
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL d2_oob_ready: got %b expected %b", rdy2, 1'b1); end
    is2 = 1; ir2 = 5'd25;
    step();
    is2 = 0;
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL d2_oob_busy: got %b expected %b", busy2, 1'b0); end
    is2 = 1; ir2 = 5'd0;
    step();
    is2 = 0;
    rr2 = 5'd0;
    #1;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL d2_r0_busy: got %b expected %b", busy2, 1'b1); end
    checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL d2_r0_ready: got %b expected %b", rdy2, 1'b0); end
  endtask

  task automatic test_reset_mid();
    Issue = 1; IssueReg = 5'd2;
    step();
    IssueReg = 5'd3;
    step();
    Issue = 0;
    ReadReg = {5'd5, 5'd2};
    #1;
    checks++; if (ReadReady !== 2'b10) begin errors++; $display("FAIL mid_pre_ready: got %b expected %b", ReadReady, 2'b10); end
    checks++; if (IssueBusy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b expected %b", IssueBusy, 1'b1); end
    reset_n = 1'b0;
    #1;
    checks++; if (ReadReady !== 2'b11) begin errors++; $display("FAIL mid_reset_ready: got %b expected %b", ReadReady, 2'b11); end
    checks++; if (ReadData !== 64'h0) begin errors++; $display("FAIL mid_reset_data: got %h expected %h", ReadData, 64'h0); end
    checks++; if (IssueBusy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected %b", IssueBusy, 1'b0); end
    step();
    reset_n = 1'b1;
    #1;
    RegWrite = 1; WriteReg = 5'd2; WriteData = 32'h1;
    step();
    RegWrite = 0;
    #1;
    checks++; if (ReadData[31:0] !== 32'h1) begin errors++; $display("FAIL post_reset_r2_data: got %h expected %h", ReadData[31:0], 32'h1); end
    checks++; if (ReadReady[0] !== 1'b1) begin errors++; $display("FAIL post_reset_r2_ready: got %b expected %b", ReadReady[0], 1'b1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_issue_pending();
    test_same_cycle();
    test_bypass();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline register file: DEPTH x DATA_W storage, NUM_READ combinational read ports, one clocked write port.
- Adds a pending-write scoreboard for RAW/WAW hazard detection, a hardwired zero register, and reset-to-zero in place of file preload.
- Sits in the ID stage. Issue logic marks destination registers; WB writes data and clears the marks.

Parameters:
- DATA_W, 32, data width in bits.
- DEPTH, 32, number of registers (2..256).
- ADDR_W, $clog2(DEPTH), register index width (derived; not to be overridden).
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- RegWrite  in  1  writeback strobe.
- WriteReg  in  ADDR_W  writeback index.
- WriteData  in  DATA_W  writeback data.
- Issue  in  1  instruction with destination issued this cycle.
- IssueReg  in  ADDR_W  destination index being issued.
- ReadReg  in  NUM_READ*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
- ReadData  out  NUM_READ*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- ReadReady  out  NUM_READ  1 = ReadData[i] is architecturally valid (no pending producer).
- IssueBusy  out  1  IssueReg currently pending (WAW indicator).

Behaviour:
- Reset, asynchronous on reset_n low:
  - All registers are set to 0 and all pending bits are cleared.
  - While reset is held, outputs are ReadData = 0, ReadReady = all 1, IssueBusy = 0.
- Write:
  - At a clock edge with RegWrite=1 and WriteReg < DEPTH: RF[WriteReg] <= WriteData and pending[WriteReg] <= 0.
  - WriteReg >= DEPTH is ignored.
  - With ZERO_REG=1, a write to index 0 is ignored.
- Issue:
  - At a clock edge with Issue=1 and IssueReg < DEPTH: pending[IssueReg] <= 1.
  - With ZERO_REG=1, issue to index 0 is ignored.
- Simultaneous Issue and RegWrite to the same index:
  - Data is written.
  - pending ends at 1, because the new producer wins.
- Reads are combinational, with zero latency from ReadReg:
  - ReadData[i] = RF[ReadReg[i]].
  - ReadData[i] = 0 if ReadReg[i] >= DEPTH, or if ZERO_REG=1 and the index is 0.
- ReadReady[i] = !pending[ReadReg[i]], subject to the bypass modification below.
  - Index 0 with ZERO_REG=1 is always ready.
  - An out-of-range index is always ready.
- IssueBusy = pending[IssueReg], combinational.
- Multiple read ports addressing the same index return identical data and ready values.
- Write and read addresses are independent. There is no port priority and no back-pressure; the issuer must stall externally on !ReadReady or IssueBusy.
- Reset mid-operation: in-flight pending marks are discarded. Writeback arriving after reset writes normally and clearing an already-clear pending bit is harmless.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read that matches a same-cycle valid write is forwarded. If RegWrite=1, WriteReg == ReadReg[i] and the index is writable, then:
  - ReadData[i] = WriteData.
  - ReadReady[i] = 1, even if pending is set.
- Not defined: reads return the stored value and the pending status until the clock edge. The reader sees the new data one cycle after writeback.

Test Plan:
- Reset with ReadReg={5,3} -> ReadData={0,0}, ReadReady=2'b11. Write 0xDEADBEEF to r5 at one edge -> port 0 reads 0xDEADBEEF on the next cycle.
- Write 0x12345678 to r0 with ZERO_REG=1 -> ReadData of r0 = 0, ReadReady = 1. Issue to r0 -> IssueBusy stays 0.
- Issue r7, then read r7 -> ReadReady=0 and IssueBusy=1 for r7. Write r7 = 0xA5 -> ready=1 and data=0xA5 the cycle after.
- Same-cycle Issue r9 and RegWrite r9 = 0x55 -> after the edge, RF[9]=0x55 and ReadReady for r9 = 0.
- With REGFILE_BYPASS_EN, pending r4 plus RegWrite r4 = 0x77 while reading r4 on both ports -> both ports show 0x77 and ready=1 in the same cycle. Without the macro -> old value and ready=0 that cycle.
- Issue r2 and r3, then assert reset_n low mid-sequence -> all pending bits clear immediately. A later write to r2 = 0x1 reads back 0x1 with ready=1.
